// File: rtl/serial_pkg.sv
// Shared types and default widths for the serial frame datapath.
package serial_pkg;

  localparam int unsigned SER_ADDR_W = 2;
  localparam int unsigned SER_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    EMIT
  } demux_state_t;

endpackage

// File: rtl/serial_port_demux_if.sv
// Serial input strobes and per-channel output bus of serial_port_demux.
interface serial_port_demux_if
  import serial_pkg::*;
#(
  parameter int unsigned ADDR_W = SER_ADDR_W,
  parameter int unsigned DATA_W = SER_DATA_W
) ();

  localparam int unsigned NUM_PORTS = 2 ** ADDR_W;

  logic                          serial_in;
  logic                          port_enable;
  logic                          smbs_enable;
  logic [NUM_PORTS*DATA_W-1:0]   ch_data;
  logic [NUM_PORTS-1:0]          ch_valid;
  logic                          busy;
  logic                          frame_err;

  modport master (
    output serial_in, port_enable, smbs_enable,
    input  ch_data, ch_valid, busy, frame_err
  );

  modport slave (
    input  serial_in, port_enable, smbs_enable,
    output ch_data, ch_valid, busy, frame_err
  );

endinterface

// File: rtl/serial_shift_reg.sv
// MSB-first serial-in shift register with synchronous clear; WIDTH must be at least 2.
module serial_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;

  // Clear and shift together load the new bit into a zeroed register.
  always_comb begin
    q_d = clear ? '0 : q;
    if (shift) begin
      q_d = {q_d[WIDTH-2:0], din};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= q_d;
    end
  end

endmodule

// File: rtl/serial_port_demux.sv
// Deserialises a port number and payload and emits the payload on the addressed channel.
// Build option SERIAL_PORT_DEMUX_PARITY_EN adds a trailing even-parity bit to the data phase.
module serial_port_demux
  import serial_pkg::*;
#(
  parameter int unsigned ADDR_W = SER_ADDR_W,
  parameter int unsigned DATA_W = SER_DATA_W
) (
  input logic                clk,
  input logic                rst,
  serial_port_demux_if.slave bus
);

  localparam int unsigned NUM_PORTS = 2 ** ADDR_W;
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned SR_W    = DATA_W + PAR_W;
  localparam int unsigned CNT_MAX = DATA_W + 1 + PAR_W;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  demux_state_t                state_q, state_d;
  logic [CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
  logic                        err_q, err_d;
  logic [NUM_PORTS*DATA_W-1:0] ch_data_q, ch_data_d;
  logic [NUM_PORTS-1:0]        ch_valid_q, ch_valid_d;
  logic                        addr_shift, data_shift, data_clear;
  logic [ADDR_W-1:0]           addr_sr;
  logic [SR_W-1:0]             data_sr;
  logic [DATA_W-1:0]           payload;
  logic                        emit_ok;

  serial_shift_reg #(.WIDTH(ADDR_W)) u_addr_sr (
    .clk  (clk),
    .rst  (rst),
    .clear(1'b0),
    .shift(addr_shift),
    .din  (bus.serial_in),
    .q    (addr_sr)
  );

  serial_shift_reg #(.WIDTH(SR_W)) u_data_sr (
    .clk  (clk),
    .rst  (rst),
    .clear(data_clear),
    .shift(data_shift),
    .din  (bus.serial_in),
    .q    (data_sr)
  );

`ifdef SERIAL_PORT_DEMUX_PARITY_EN
  assign payload = data_sr[SR_W-1:1];
  assign emit_ok = (bit_cnt_q == CNT_W'(DATA_W + 1)) && (data_sr[0] == ^payload);
`else
  assign payload = data_sr;
  assign emit_ok = (bit_cnt_q != '0);
`endif

  // Channel outputs are registered on the DATA->EMIT edge so they are visible during EMIT.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    err_d      = err_q;
    ch_data_d  = ch_data_q;
    ch_valid_d = '0;
    addr_shift = 1'b0;
    data_shift = 1'b0;
    data_clear = 1'b0;

    if (bus.port_enable && bus.smbs_enable) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (bus.port_enable) begin
          addr_shift = 1'b1;
          state_d    = ADDR;
        end else if (bus.smbs_enable) begin
          err_d = 1'b1;
        end
      end
      ADDR: begin
        if (bus.port_enable) begin
          addr_shift = 1'b1;
        end else if (bus.smbs_enable) begin
          bit_cnt_d  = CNT_W'(1);
          data_clear = 1'b1;
          data_shift = 1'b1;
          state_d    = DATA;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      DATA: begin
        if (bus.port_enable) begin
          addr_shift = 1'b1;
          state_d    = ADDR;
        end else if (bus.smbs_enable) begin
          data_shift = 1'b1;
          if (bit_cnt_q != CNT_W'(CNT_MAX)) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (bit_cnt_d == CNT_W'(CNT_MAX)) begin
            err_d = 1'b1;
          end
        end else begin
          state_d = EMIT;
          if (emit_ok) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
              if (addr_sr == ADDR_W'(k)) begin
                ch_data_d[k*DATA_W +: DATA_W] = payload;
                ch_valid_d[k]                 = 1'b1;
              end
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      EMIT: begin
        // A port bit arriving here is dropped rather than starting a new frame.
        state_d = IDLE;
        if (bus.port_enable) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      err_q      <= 1'b0;
      ch_data_q  <= '0;
      ch_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      err_q      <= err_d;
      ch_data_q  <= ch_data_d;
      ch_valid_q <= ch_valid_d;
    end
  end

  assign bus.ch_data   = ch_data_q;
  assign bus.ch_valid  = ch_valid_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.frame_err = err_q;

endmodule

// File: tb/tb_serial_port_demux.sv
// Self-checking bench for serial_port_demux: frame vector table plus hand-written corner sequences.
module tb_serial_port_demux;
  import serial_pkg::*;

  localparam int unsigned AW = SER_ADDR_W;
  localparam int unsigned DW = SER_DATA_W;
  localparam int unsigned NP = 1 << AW;
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
  localparam int NOM_LEN = DW + 1;
`else
  localparam int NOM_LEN = DW;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_port_demux_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  serial_port_demux #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int            alen;
    logic [15:0]   abits;
    int            dlen;
    logic [15:0]   dbits;
    bit            exp_valid;
    int            exp_ch;
    logic [DW-1:0] exp_data;
    bit            exp_err;
  } vec_t;

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  vec_t          vecs[$];
  logic [DW-1:0] model[NP];
  int            n_cmp  = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NP*DW-1:0] model_flat();
    logic [NP*DW-1:0] r;
    for (int k = 0; k < NP; k++) r[k*DW +: DW] = model[k];
    return r;
  endfunction

  // Payload bits as sent on the wire, with the parity bit appended when enabled.
  function automatic logic [15:0] wire_bits(input logic [DW-1:0] d);
`ifdef SERIAL_PORT_DEMUX_PARITY_EN
    return 16'({d, ^d});
`else
    return 16'(d);
`endif
  endfunction

  // Scoreboard consumer: every valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && bus.ch_valid != '0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_valid: got ch_valid 0x%0h, expected no pulse", bus.ch_valid);
      end else begin
        mon_e = sb.pop_front();
        model[mon_e.ch] = mon_e.data;
        check("ch_valid", 64'(bus.ch_valid), 64'(NP'(1) << mon_e.ch));
        check("ch_data", 64'(bus.ch_data), 64'(model_flat()));
      end
    end
  end

  task automatic drive(input logic p, input logic s, input logic b);
    bus.port_enable = p;
    bus.smbs_enable = s;
    bus.serial_in   = b;
  endtask

  task automatic send_frame(input int alen, input logic [15:0] abits,
                            input int dlen, input logic [15:0] dbits);
    for (int i = alen - 1; i >= 0; i--) begin
      @(negedge clk);
      drive(1'b1, 1'b0, abits[i]);
    end
    for (int i = dlen - 1; i >= 0; i--) begin
      @(negedge clk);
      drive(1'b0, 1'b1, dbits[i]);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_exp(input int ch, input logic [DW-1:0] d);
    exp_t e;
    e.ch   = ch;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ch_data"}, 64'(bus.ch_data), 64'(0));
    check({tag, "_ch_valid"}, 64'(bus.ch_valid), 64'(0));
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_frame_err"}, 64'(bus.frame_err), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("sb_drained_before_reset", 64'(sb.size()), 64'(0));
    sb.delete();
    for (int k = 0; k < NP; k++) model[k] = '0;
    rst = 1'b0;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < NP; k++) model[k] = '0;

`ifdef SERIAL_PORT_DEMUX_PARITY_EN
    vecs.push_back('{2, 16'b10, 9, 16'h14A, 1'b1, 2, 8'hA5, 1'b0});
    vecs.push_back('{2, 16'b10, 9, 16'h14B, 1'b0, 0, 8'h00, 1'b1});
    vecs.push_back('{2, 16'b01, 9, 16'h078, 1'b1, 1, 8'h3C, 1'b0});
    vecs.push_back('{2, 16'b11, 9, 16'h00F, 1'b1, 3, 8'h07, 1'b0});
    vecs.push_back('{2, 16'b00, 8, 16'hA5,  1'b0, 0, 8'h00, 1'b1});
    vecs.push_back('{2, 16'b00, 10, 16'h294, 1'b0, 0, 8'h00, 1'b1});
    vecs.push_back('{2, 16'b10, 0, 16'h0,   1'b0, 0, 8'h00, 1'b1});
`else
    vecs.push_back('{2, 16'b10,     8, 16'hA5,           1'b1, 2, 8'hA5, 1'b0});
    vecs.push_back('{6, 16'b110101, 8, 16'h3C,           1'b1, 1, 8'h3C, 1'b0});
    vecs.push_back('{2, 16'b11,     5, 16'b10110,        1'b1, 3, 8'h16, 1'b0});
    vecs.push_back('{2, 16'b00,    10, 16'b1101011010,   1'b1, 0, 8'h5A, 1'b1});
    vecs.push_back('{2, 16'b01,     9, 16'h101,          1'b1, 1, 8'h01, 1'b1});
    vecs.push_back('{3, 16'b011,    1, 16'b1,            1'b1, 3, 8'h01, 1'b0});
    vecs.push_back('{2, 16'b10,     0, 16'h0,            1'b0, 0, 8'h00, 1'b1});
    vecs.push_back('{2, 16'b00,     8, 16'h81,           1'b1, 0, 8'h81, 1'b0});
`endif

    foreach (vecs[i]) begin
      do_reset();
      if (vecs[i].exp_valid) push_exp(vecs[i].exp_ch, vecs[i].exp_data);
      send_frame(vecs[i].alen, vecs[i].abits, vecs[i].dlen, vecs[i].dbits);
      repeat (2) @(negedge clk);
      check($sformatf("vec%0d_frame_err", i), 64'(bus.frame_err), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_busy", i), 64'(bus.busy), 64'(0));
      check($sformatf("vec%0d_pending", i), 64'(sb.size()), 64'(0));
    end

    // Valid pulse timing: one cycle, during EMIT, right after smbs_enable drops.
    do_reset();
    push_exp(2, 8'hA5);
    send_frame(2, 16'b10, NOM_LEN, wire_bits(8'hA5));
    @(negedge clk);
    check("lat_valid_on", 64'(bus.ch_valid), 64'(4'b0100));
    check("lat_data", 64'(bus.ch_data), 64'(32'h00A5_0000));
    check("lat_busy_emit", 64'(bus.busy), 64'(1));
    @(negedge clk);
    check("lat_valid_off", 64'(bus.ch_valid), 64'(0));
    check("lat_busy_idle", 64'(bus.busy), 64'(0));

    // Reset in the middle of a data phase: nothing may be emitted.
    do_reset();
    repeat (2) begin @(negedge clk); drive(1'b1, 1'b0, 1'b1); end
    repeat (3) begin @(negedge clk); drive(1'b0, 1'b1, 1'b1); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_idle_outputs("midrst_after");

    // Data strobe with no address phase.
    do_reset();
    repeat (2) begin @(negedge clk); drive(1'b0, 1'b1, 1'b1); end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("orphan_data_err", 64'(bus.frame_err), 64'(1));
    check("orphan_data_busy", 64'(bus.busy), 64'(0));

    // Both strobes high: error flagged, port wins and the frame continues as address.
    do_reset();
    push_exp(2, 8'h11);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check("both_high_err", 64'(bus.frame_err), 64'(1));
    check("both_high_busy", 64'(bus.busy), 64'(1));
    drive(1'b1, 1'b0, 1'b0);
    send_frame(0, 16'h0, NOM_LEN, wire_bits(8'h11));
    repeat (2) @(negedge clk);
    check("both_high_pending", 64'(sb.size()), 64'(0));

    // Back-to-back frames with one IDLE cycle between them.
    do_reset();
    push_exp(1, 8'h3C);
    push_exp(2, 8'hC3);
    send_frame(2, 16'b01, NOM_LEN, wire_bits(8'h3C));
    @(negedge clk);
    send_frame(2, 16'b10, NOM_LEN, wire_bits(8'hC3));
    repeat (2) @(negedge clk);
    check("b2b_err", 64'(bus.frame_err), 64'(0));
    check("b2b_pending", 64'(sb.size()), 64'(0));

    // Port strobe arriving during EMIT is dropped and flagged.
    do_reset();
    push_exp(1, 8'h5A);
    send_frame(2, 16'b01, NOM_LEN, wire_bits(8'h5A));
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("emit_port_err", 64'(bus.frame_err), 64'(1));
    check("emit_port_busy", 64'(bus.busy), 64'(0));
    check("emit_port_pending", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_port_demux.md
Name: serial_port_demux

Overview:
- Datapath stage directly downstream of the serial frame controller.
- Consumes the controller's registered serial bit and its two phase strobes, port_enable and smbs_enable.
- During the address phase it deserialises a port number; during the data phase it deserialises a payload.
- At the end of the data phase it latches the payload onto the addressed output channel with a one-cycle valid pulse.

Parameters:
- ADDR_W, 2, address bits retained from address phase; NUM_PORTS = 2**ADDR_W.
- DATA_W, 8, payload bits per channel.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- serial_in  in  1  serial bit stream, MSB first.
- port_enable  in  1  high during address phase.
- smbs_enable  in  1  high during data phase.
- ch_data  out  NUM_PORTS*DATA_W  channel payloads; channel k occupies bits [k*DATA_W +: DATA_W].
- ch_valid  out  NUM_PORTS  one-cycle pulse per channel on update.
- busy  out  1  high in ADDR, DATA or EMIT.
- frame_err  out  1  sticky error flag; cleared by rst only.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high. Inputs are driven on the falling edge upstream and are sampled here on the rising edge of clk.
- Reset values: ch_data=0, ch_valid=0, busy=0, frame_err=0, FSM=IDLE, addr_sr=0, data_sr=0, bit_cnt=0.
- FSM states: IDLE, ADDR, DATA, EMIT.
- IDLE:
  - port_enable=1: shift serial_in into addr_sr, go to ADDR.
  - smbs_enable=1 with port_enable=0: set frame_err, stay in IDLE.
- ADDR, while port_enable=1:
  - addr_sr <= {addr_sr[ADDR_W-2:0], serial_in}.
  - Longer phases keep only the last ADDR_W bits.
- ADDR exit:
  - port_enable=0 and smbs_enable=1: clear bit_cnt, shift first data bit, go to DATA.
  - Both enables 0: abort to IDLE, no output, set frame_err.
- DATA, while smbs_enable=1:
  - data_sr <= {data_sr[DATA_W-2:0], serial_in}.
  - bit_cnt saturates at DATA_W+1.
  - bit_cnt reaching DATA_W+1 (overflow) sets frame_err; data_sr keeps the last DATA_W bits.
- DATA exit, on smbs_enable=0: go to EMIT.
- EMIT (exactly one cycle), then go to IDLE:
  - If bit_cnt>=1: write data_sr into the ch_data slice for channel addr_sr and pulse ch_valid[addr_sr] high for this cycle only.
  - Short frames (bit_cnt<DATA_W) are emitted zero-extended on the left.
  - bit_cnt=0 is impossible by construction.
  - Other channels' ch_data hold their values.
- Latency: ch_valid asserts on the first rising edge after smbs_enable is sampled low (1 cycle).
- Simultaneous port_enable=1 and smbs_enable=1 in any state: set frame_err; port_enable wins.
  - In DATA, this discards the partial payload and restarts ADDR with the current bit.
- port_enable rising in EMIT: handled after EMIT. That bit is lost, frame_err is set, and the FSM goes to IDLE.
- rst mid-frame: immediate return to reset values; the partial frame is never emitted.
- Back-to-back frames separated by a single idle cycle must be accepted.

Optional Feature:
- Macro: SERIAL_PORT_DEMUX_PARITY_EN.
- Defined:
  - The data phase carries DATA_W payload bits plus one trailing even-parity bit; bit_cnt limit becomes DATA_W+2.
  - In EMIT, the parity bit is checked against XOR of the payload.
  - On mismatch, or a frame length other than DATA_W+1: no ch_valid, no ch_data update, frame_err set.
- Undefined: no parity bit; behaviour exactly as above.

Decomposition:
- Shared package serial_pkg:
  - state enum type demux_state_t {IDLE, ADDR, DATA, EMIT}.
  - Default constants SER_ADDR_W=2 and SER_DATA_W=8, also used by the controller side.
- One natural sub-module: serial_shift_reg (parameterised width, shift-enable, MSB-first).
  - Instantiated twice: addr_sr and data_sr.

Test Plan:
- Reset: hold rst 2 cycles mid-frame → all outputs 0, FSM IDLE, no ch_valid.
- Nominal frame:
  - Stimulus: port_enable 2 cycles with bits 1,0 (addr 2), then smbs_enable 8 cycles with 0xA5 MSB first.
  - Response: ch_data[23:16]=0xA5, ch_valid=4'b0100 for exactly 1 cycle, 1 cycle after smbs_enable falls; other slices 0.
- Long address phase: 6-cycle address bits 1,1,0,1,0,1 → only last 2 bits kept, addr=1; payload 0x3C lands on channel 1.
- Short/over frames:
  - 5-bit payload 10110 → channel gets 0x16, frame_err stays 0.
  - 10-bit payload → last 8 bits emitted, frame_err=1.
- Protocol errors:
  - smbs_enable without a preceding address phase → frame_err=1, no ch_valid.
  - Both enables high simultaneously → frame_err=1.
- Parity (macro defined):
  - 0xA5 with parity 0 → emitted.
  - 0xA5 with parity 1 → no ch_valid, frame_err=1.
